// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU with valid/ready handshakes on issue and result.
// Arithmetic, logic and compare ops finish in one cycle; shifts move one bit per cycle.
module alu_exec_unit #(
    parameter int unsigned REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                alu_op,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic                      alu_src_a,
    input  logic                      alu_src_b,
    input  logic [REG_DATA_WIDTH-1:0] rs1_data,
    input  logic [REG_DATA_WIDTH-1:0] rs2_data,
    input  logic [REG_DATA_WIDTH-1:0] pc,
    input  logic [REG_DATA_WIDTH-1:0] imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [REG_DATA_WIDTH-1:0] result,
    output logic                      zero,
    output logic                      illegal
);

    localparam int unsigned ShW = $clog2(REG_DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
    typedef enum logic [1:0] {ShSll, ShSrl, ShSra} shift_e;

    state_e                    state_q;
    shift_e                    shk_q;
    logic [REG_DATA_WIDTH-1:0] acc_q;
    logic [ShW-1:0]            cnt_q;
    logic                      zero_q;
    logic                      illegal_q;

    logic [REG_DATA_WIDTH-1:0] op_a;
    logic [REG_DATA_WIDTH-1:0] op_b;
    logic [ShW-1:0]            shamt;
    logic [REG_DATA_WIDTH-1:0] res_c;
    logic                      is_shift_c;
    shift_e                    shk_c;
    logic                      ill_c;
    logic [REG_DATA_WIDTH-1:0] acc_d;

    assign op_a  = alu_src_a ? pc : rs1_data;
    assign op_b  = alu_src_b ? imm : rs2_data;
    assign shamt = op_b[ShW-1:0];

    // Shift ops report A as their immediate result so shamt==0 completes like a 1-cycle op.
    always_comb begin
        res_c      = '0;
        is_shift_c = 1'b0;
        shk_c      = ShSll;
        ill_c      = 1'b0;
        case (alu_op)
            2'b00: res_c = op_a + op_b;
            2'b01: res_c = op_a - op_b;
            2'b11: ill_c = 1'b1;
            default: begin
                case (funct3)
                    3'b000: res_c = (funct7 == 7'b0100000 && !alu_src_b) ? op_a - op_b
                                                                         : op_a + op_b;
                    3'b001: begin
                        res_c      = op_a;
                        is_shift_c = 1'b1;
                        shk_c      = ShSll;
                    end
                    3'b010: res_c = {{(REG_DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    3'b011: res_c = {{(REG_DATA_WIDTH-1){1'b0}}, op_a < op_b};
                    3'b100: res_c = op_a ^ op_b;
                    3'b101: begin
                        res_c      = op_a;
                        is_shift_c = 1'b1;
                        shk_c      = funct7[5] ? ShSra : ShSrl;
                    end
                    3'b110: res_c = op_a | op_b;
                    default: res_c = op_a & op_b;
                endcase
            end
        endcase
    end

    always_comb begin
        case (shk_q)
            ShSrl:   acc_d = acc_q >> 1;
            ShSra:   acc_d = {acc_q[REG_DATA_WIDTH-1], acc_q[REG_DATA_WIDTH-1:1]};
            default: acc_d = acc_q << 1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shk_q     <= ShSll;
            acc_q     <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        illegal_q <= ill_c;
                        if (is_shift_c && shamt != '0) begin
                            acc_q   <= op_a;
                            cnt_q   <= shamt;
                            shk_q   <= shk_c;
                            state_q <= StShift;
                        end else begin
                            acc_q   <= res_c;
                            zero_q  <= (res_c == '0);
                            state_q <= StDone;
                        end
                    end
                end
                StShift: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - ShW'(1);
                    if (cnt_q == ShW'(1)) begin
                        zero_q  <= (acc_d == '0);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = acc_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations queued at issue, popped when out_valid rises.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        sa;
        logic        sb;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pcv;
        logic [31:0] immv;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];

    alu_exec_unit #(.REG_DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .pc        (pc),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Drives one issue for a single edge, then counts cycles until out_valid (bounded).
    task automatic issue(input vec_t v, output int lat);
        @(negedge clk);
        alu_op    = v.op;
        funct3    = v.f3;
        funct7    = v.f7;
        alu_src_a = v.sa;
        alu_src_b = v.sb;
        rs1_data  = v.rs1;
        rs2_data  = v.rs2;
        pc        = v.pcv;
        imm       = v.immv;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_vectors(input string name, input vec_t vs[$]);
        exp_t e;
        int   lat;
        foreach (vs[i]) begin
            sb_q.push_back(vs[i].e);
            issue(vs[i], lat);
            e = sb_q.pop_front();
            checks++;
            if (result !== e.res || zero !== e.zero || illegal !== e.ill || lat !== e.lat)
                $display("FAIL %s[%0d]: got res=%h zero=%b ill=%b lat=%0d, want res=%h zero=%b ill=%b lat=%0d",
                         name, i, result, zero, illegal, lat, e.res, e.zero, e.ill, e.lat);
            else
                passes++;
            release_result();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_hs: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        else passes++;
        checks++;
        if (result !== 32'h0 || zero !== 1'b1 || illegal !== 1'b0)
            $display("FAIL reset_out: got res=%h zero=%b ill=%b, want 0 1 0", result, zero, illegal);
        else passes++;
    endtask

    task automatic test_add_hold();
        vec_t v;
        exp_t e;
        int   lat;
        v = '{op: 2'b00, f3: 3'b000, f7: 7'h00, sa: 1'b1, sb: 1'b1, rs1: 32'h0, rs2: 32'h0,
              pcv: 32'h1000, immv: 32'hFFFF_FFFC, e: '{32'h0000_0FFC, 1'b0, 1'b0, 1}};
        sb_q.push_back(v.e);
        issue(v, lat);
        e = sb_q.pop_front();
        checks++;
        if (result !== e.res || zero !== e.zero || lat !== e.lat)
            $display("FAIL add_pc_imm: got res=%h zero=%b lat=%0d, want res=%h zero=%b lat=%0d",
                     result, zero, lat, e.res, e.zero, e.lat);
        else passes++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (result !== e.res || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL hold[%0d]: got res=%h out_valid=%b in_ready=%b, want %h 1 0",
                         c, result, out_valid, in_ready, e.res);
            else passes++;
        end
        release_result();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        else passes++;
    endtask

    task automatic test_sub_addi();
        vec_t vs[$];
        vs.push_back('{2'b10, 3'b000, 7'h20, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 32'd7,
                       '{32'hFFFF_FFFE, 1'b0, 1'b0, 1}});
        vs.push_back('{2'b10, 3'b000, 7'h20, 1'b0, 1'b1, 32'd5, 32'd7, 32'h0, 32'd7,
                       '{32'd12, 1'b0, 1'b0, 1}});
        vs.push_back('{2'b01, 3'b000, 7'h00, 1'b0, 1'b0, 32'd9, 32'd9, 32'h0, 32'h0,
                       '{32'd0, 1'b1, 1'b0, 1}});
        vs.push_back('{2'b10, 3'b100, 7'h00, 1'b0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0,
                       32'h0, '{32'hFF00_0FF0, 1'b0, 1'b0, 1}});
        vs.push_back('{2'b10, 3'b110, 7'h00, 1'b0, 1'b1, 32'h0000_1200, 32'h0, 32'h0,
                       32'h0000_0034, '{32'h0000_1234, 1'b0, 1'b0, 1}});
        vs.push_back('{2'b10, 3'b111, 7'h00, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0,
                       32'h0, '{32'h0F00_0F00, 1'b0, 1'b0, 1}});
        run_vectors("arith_logic", vs);
    endtask

    task automatic test_shifts();
        vec_t vs[$];
        vs.push_back('{2'b10, 3'b101, 7'h20, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 32'h0, 32'h0,
                       '{32'hFFFF_FFFF, 1'b0, 1'b0, 32}});
        vs.push_back('{2'b10, 3'b101, 7'h00, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 32'h0, 32'h0,
                       '{32'h0000_0001, 1'b0, 1'b0, 32}});
        // Operand B of 32 has shamt 0 once the upper bits are dropped.
        vs.push_back('{2'b10, 3'b101, 7'h20, 1'b0, 1'b0, 32'h8000_0000, 32'd32, 32'h0, 32'h0,
                       '{32'h8000_0000, 1'b0, 1'b0, 1}});
        vs.push_back('{2'b10, 3'b001, 7'h00, 1'b0, 1'b1, 32'h0000_0003, 32'h0, 32'h0, 32'h21,
                       '{32'h0000_0006, 1'b0, 1'b0, 2}});
        vs.push_back('{2'b10, 3'b001, 7'h00, 1'b0, 1'b0, 32'h0000_0003, 32'd31, 32'h0, 32'h0,
                       '{32'h8000_0000, 1'b0, 1'b0, 32}});
        vs.push_back('{2'b10, 3'b001, 7'h00, 1'b0, 1'b0, 32'h0000_0002, 32'd31, 32'h0, 32'h0,
                       '{32'h0000_0000, 1'b1, 1'b0, 32}});
        run_vectors("shift", vs);
    endtask

    task automatic test_compare_illegal();
        vec_t vs[$];
        vs.push_back('{2'b10, 3'b010, 7'h00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0,
                       '{32'd1, 1'b0, 1'b0, 1}});
        vs.push_back('{2'b10, 3'b011, 7'h00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0,
                       '{32'd0, 1'b1, 1'b0, 1}});
        vs.push_back('{2'b11, 3'b000, 7'h00, 1'b0, 1'b0, 32'd4, 32'd4, 32'h0, 32'h0,
                       '{32'd0, 1'b1, 1'b1, 1}});
        vs.push_back('{2'b00, 3'b000, 7'h00, 1'b0, 1'b0, 32'd4, 32'd4, 32'h0, 32'h0,
                       '{32'd8, 1'b0, 1'b0, 1}});
        run_vectors("cmp_illegal", vs);
    endtask

    task automatic test_reset_abort();
        logic seen = 1'b0;
        vec_t vs[$];
        @(negedge clk);
        alu_op    = 2'b10;
        funct3    = 3'b001;
        funct7    = 7'h00;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        rs1_data  = 32'd1;
        rs2_data  = 32'd20;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1)
            $display("FAIL abort_state: got in_ready=%b out_valid=%b res=%h zero=%b, want 1 0 0 1",
                     in_ready, out_valid, result, zero);
        else passes++;
        for (int c = 0; c < 25; c++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0)
            $display("FAIL abort_no_output: got out_valid seen=%b, want 0", seen);
        else passes++;
        vs.push_back('{2'b00, 3'b000, 7'h00, 1'b0, 1'b0, 32'd2, 32'd3, 32'h0, 32'h0,
                       '{32'd5, 1'b0, 1'b0, 1}});
        run_vectors("after_abort", vs);
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        @(negedge clk);
        alu_op    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        rs1_data  = 32'd10;
        rs2_data  = 32'd20;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pat[5-c] = out_valid;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (pat !== 6'b101010 || result !== 32'd30)
            $display("FAIL back_to_back: got pattern=%b res=%0d, want 101010 30", pat, result);
        else passes++;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct3    = 3'b000;
        funct7    = 7'h00;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        rs1_data  = '0;
        rs2_data  = '0;
        pc        = '0;
        imm       = '0;
        test_reset();
        test_add_hold();
        test_sub_addi();
        test_shifts();
        test_compare_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
